// File: rtl/led_pattern_sequencer_param.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_sequencer_param
// Brief    : WIDTH-LED pattern sequencer with four step rates, nine patterns
//            (walk, bounce, Johnson, count, alternate, LFSR, blink), a pause
//            control and a step-tick strobe. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_sequencer_param #(
  parameter int               WIDTH     = 8,
  parameter int               RATE0_DIV = 10000000,
  parameter int               RATE1_DIV = 2500000,
  parameter int               RATE2_DIV = 1000000,
  parameter int               RATE3_DIV = 250000,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(8'hB8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       rate_sel,
  input  logic [3:0]       pattern_sel,
  input  logic             pause,
  output logic [WIDTH-1:0] led_out,
  output logic             step_tick,
  output logic [3:0]       pattern_active
);

  localparam int C_MAX01   = (RATE0_DIV > RATE1_DIV) ? RATE0_DIV : RATE1_DIV;
  localparam int C_MAX23   = (RATE2_DIV > RATE3_DIV) ? RATE2_DIV : RATE3_DIV;
  localparam int C_MAX_DIV = (C_MAX01 > C_MAX23) ? C_MAX01 : C_MAX23;
  localparam int C_CNT_W   = $clog2(C_MAX_DIV) + 1;

  localparam logic [3:0] C_PAT_OFF   = 4'd0;
  localparam logic [3:0] C_PAT_WALKL = 4'd1;
  localparam logic [3:0] C_PAT_WALKR = 4'd2;
  localparam logic [3:0] C_PAT_BNCE  = 4'd3;
  localparam logic [3:0] C_PAT_JOHN  = 4'd4;
  localparam logic [3:0] C_PAT_COUNT = 4'd5;
  localparam logic [3:0] C_PAT_ALT   = 4'd6;
  localparam logic [3:0] C_PAT_LFSR  = 4'd7;
  localparam logic [3:0] C_PAT_BLINK = 4'd8;

  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_MSB  = C_ONE << (WIDTH - 1);
  localparam logic [WIDTH-1:0] C_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0]   led_q, led_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               tick_q, tick_d;
  logic [3:0]         active_q, active_d;

  logic [C_CNT_W-1:0] w_div;
  logic               w_cnt_end;
  logic               w_pat_change;
  logic [WIDTH-1:0]   w_alt_seed;
  logic [WIDTH-1:0]   w_seed;
  logic [WIDTH-1:0]   w_adv_led;
  logic               w_adv_dir;

  // Alternate-pattern seed: even bits set, only within the whole 2-bit pairs
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_alt
    assign w_alt_seed[gi] = ((gi % 2) == 0) && (gi < 2 * (WIDTH / 2));
  end

  assign w_pat_change = (pattern_sel != active_q);
  // ">=" lets a switch to a shorter divider tick at once instead of wrapping
  assign w_cnt_end    = (cnt_q >= (w_div - C_CNT_W'(1)));

  // Select the clocks-per-step divider for the current rate
  always_comb begin
    case (rate_sel)
      2'd0:    w_div = C_CNT_W'(RATE0_DIV);
      2'd1:    w_div = C_CNT_W'(RATE1_DIV);
      2'd2:    w_div = C_CNT_W'(RATE2_DIV);
      default: w_div = C_CNT_W'(RATE3_DIV);
    endcase
  end

  // Seed value loaded when a new pattern is requested
  always_comb begin
    case (pattern_sel)
      C_PAT_WALKL: w_seed = C_ONE;
      C_PAT_WALKR: w_seed = C_MSB;
      C_PAT_BNCE:  w_seed = C_ONE;
      C_PAT_ALT:   w_seed = w_alt_seed;
      C_PAT_LFSR:  w_seed = C_ONES;
      C_PAT_BLINK: w_seed = C_ONES;
      default:     w_seed = '0;
    endcase
  end

  // One-step advance of the running pattern; reserved codes stay dark
  always_comb begin
    w_adv_led = '0;
    w_adv_dir = dir_q;
    case (active_q)
      C_PAT_OFF:   w_adv_led = '0;
      C_PAT_WALKL: w_adv_led = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
      C_PAT_WALKR: w_adv_led = {led_q[0], led_q[WIDTH-1:1]};
      C_PAT_BNCE: begin
        if (!dir_q) begin
          if (led_q[WIDTH-1]) begin
            w_adv_led = led_q >> 1;
            w_adv_dir = 1'b1;
          end else begin
            w_adv_led = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            w_adv_led = led_q << 1;
            w_adv_dir = 1'b0;
          end else begin
            w_adv_led = led_q >> 1;
          end
        end
      end
      C_PAT_JOHN:  w_adv_led = {led_q[WIDTH-2:0], ~led_q[WIDTH-1]};
      C_PAT_COUNT: w_adv_led = led_q + C_ONE;
      C_PAT_ALT:   w_adv_led = ~led_q;
      C_PAT_LFSR:  w_adv_led = (led_q >> 1) ^ (led_q[0] ? LFSR_TAPS : '0);
      C_PAT_BLINK: w_adv_led = ~led_q;
      default:     w_adv_led = '0;
    endcase
  end

  // Next state: pattern change beats pause, pause beats the prescaler
  always_comb begin
    active_d = active_q;
    led_d    = led_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    tick_d   = 1'b0;
    if (w_pat_change) begin
      active_d = pattern_sel;
      led_d    = w_seed;
      cnt_d    = '0;
      dir_d    = 1'b0;
    end else if (!pause) begin
      if (w_cnt_end) begin
        cnt_d  = '0;
        led_d  = w_adv_led;
        dir_d  = w_adv_dir;
        tick_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + C_CNT_W'(1);
      end
    end
  end

  // State registers; reset clears the outputs, prescaler and bounce direction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q    <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      tick_q   <= 1'b0;
      active_q <= 4'd0;
    end else begin
      led_q    <= led_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      tick_q   <= tick_d;
      active_q <= active_d;
    end
  end

  assign led_out        = led_q;
  assign step_tick      = tick_q;
  assign pattern_active = active_q;

endmodule
`default_nettype wire
